// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-bank port between two requesters.
// Latency: bank request one edge after the request is seen; sN_rdy one edge after m_rdy.
// Backpressure: requesters hold cs until rdy; the loser waits. Optional watchdog under REG_ARB_TIMEOUT_EN.
module reg_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_cs,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic                  s0_wr_en,
  input  logic                  s0_rd_en,
  input  logic [DATA_WIDTH-1:0] s0_data_wr,
  output logic [DATA_WIDTH-1:0] s0_data_rd,
  output logic                  s0_rdy,
  input  logic                  s1_cs,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic                  s1_wr_en,
  input  logic                  s1_rd_en,
  input  logic [DATA_WIDTH-1:0] s1_data_wr,
  output logic [DATA_WIDTH-1:0] s1_data_rd,
  output logic                  s1_rdy,
  output logic                  m_cs,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_wr_en,
  output logic                  m_rd_en,
  output logic [DATA_WIDTH-1:0] m_data_wr,
  input  logic [DATA_WIDTH-1:0] m_data_rd,
  input  logic                  m_rdy,
  output logic                  grant,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [DATA_WIDTH-1:0] ERR_RD = DATA_WIDTH'(ERR_DATA);

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  aborted_q, aborted_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  m_cs_q, m_cs_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic                  m_wr_en_q, m_wr_en_d;
  logic                  m_rd_en_q, m_rd_en_d;
  logic [DATA_WIDTH-1:0] m_data_wr_q, m_data_wr_d;
  logic [DATA_WIDTH-1:0] s0_data_rd_q, s0_data_rd_d;
  logic [DATA_WIDTH-1:0] s1_data_rd_q, s1_data_rd_d;
  logic                  s0_rdy_q, s0_rdy_d;
  logic                  s1_rdy_q, s1_rdy_d;

  logic                  req0, req1, sel, sel_wr, gnt_cs, abort_now, expired;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data_wr, rsp_data;

  // A request needs cs plus at least one strobe; wr_en wins when both strobes are set.
  assign req0        = s0_cs & (s0_wr_en | s0_rd_en);
  assign req1        = s1_cs & (s1_wr_en | s1_rd_en);
  assign sel         = req1 & (~req0 | ~last_grant_q);
  assign sel_addr    = sel ? s1_addr    : s0_addr;
  assign sel_data_wr = sel ? s1_data_wr : s0_data_wr;
  assign sel_wr      = sel ? s1_wr_en   : s0_wr_en;
  assign gnt_cs      = grant_q ? s1_cs : s0_cs;
  // A cs drop on the completing edge itself also discards the response.
  assign abort_now   = aborted_q | ~gnt_cs;
  assign rsp_data    = expired ? ERR_RD : m_data_rd;

`ifdef REG_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  // m_rdy on the expiry edge wins, so expiry requires m_rdy low.
  assign expired = (state_q == ST_WAIT) && !m_rdy && (cnt_q == TO_LAST);
`else
  assign expired = 1'b0;
`endif

  // Next-state and next-output computation for the IDLE -> WAIT -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    aborted_d    = aborted_q;
    m_cs_d       = m_cs_q;
    m_addr_d     = m_addr_q;
    m_wr_en_d    = m_wr_en_q;
    m_rd_en_d    = m_rd_en_q;
    m_data_wr_d  = m_data_wr_q;
    s0_data_rd_d = s0_data_rd_q;
    s1_data_rd_d = s1_data_rd_q;
    s0_rdy_d     = 1'b0;
    s1_rdy_d     = 1'b0;
    err_d        = 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        aborted_d = 1'b0;
        if (req0 || req1) begin
          state_d      = ST_WAIT;
          grant_d      = sel;
          last_grant_d = sel;
          m_cs_d       = 1'b1;
          m_addr_d     = sel_addr;
          m_data_wr_d  = sel_data_wr;
          m_wr_en_d    = sel_wr;
          m_rd_en_d    = ~sel_wr;
`ifdef REG_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      ST_WAIT: begin
`ifdef REG_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        if (!gnt_cs) aborted_d = 1'b1;
        if (m_rdy || expired) begin
          state_d   = ST_RESP;
          m_cs_d    = 1'b0;
          m_wr_en_d = 1'b0;
          m_rd_en_d = 1'b0;
          err_d     = expired;
          if (!abort_now) begin
            if (grant_q) begin
              s1_rdy_d = 1'b1;
              if (m_rd_en_q) s1_data_rd_d = rsp_data;
            end else begin
              s0_rdy_d = 1'b1;
              if (m_rd_en_q) s0_data_rd_d = rsp_data;
            end
          end
        end
      end
      // One idle-bound cycle lets the requester drop cs before re-arbitration.
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // All state and outputs are registered; reset drops the bank request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      m_cs_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wr_en_q    <= 1'b0;
      m_rd_en_q    <= 1'b0;
      m_data_wr_q  <= '0;
      s0_data_rd_q <= '0;
      s1_data_rd_q <= '0;
      s0_rdy_q     <= 1'b0;
      s1_rdy_q     <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      m_cs_q       <= m_cs_d;
      m_addr_q     <= m_addr_d;
      m_wr_en_q    <= m_wr_en_d;
      m_rd_en_q    <= m_rd_en_d;
      m_data_wr_q  <= m_data_wr_d;
      s0_data_rd_q <= s0_data_rd_d;
      s1_data_rd_q <= s1_data_rd_d;
      s0_rdy_q     <= s0_rdy_d;
      s1_rdy_q     <= s1_rdy_d;
`ifdef REG_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign m_cs       = m_cs_q;
  assign m_addr     = m_addr_q;
  assign m_wr_en    = m_wr_en_q;
  assign m_rd_en    = m_rd_en_q;
  assign m_data_wr  = m_data_wr_q;
  assign s0_data_rd = s0_data_rd_q;
  assign s1_data_rd = s1_data_rd_q;
  assign s0_rdy     = s0_rdy_q;
  assign s1_rdy     = s1_rdy_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: bank-side and requester-side expectation queues.
module tb_reg_bus_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_cs, s0_wr_en, s0_rd_en, s1_cs, s1_wr_en, s1_rd_en;
  logic [15:0] s0_addr, s0_data_wr, s1_addr, s1_data_wr;
  logic [15:0] s0_data_rd, s1_data_rd;
  logic        s0_rdy, s1_rdy;
  logic        m_cs, m_wr_en, m_rd_en, m_rdy;
  logic [15:0] m_addr, m_data_wr, m_data_rd;
  logic        grant, busy, err;

  reg_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TO), .ERR_DATA(16'hDEAD)) dut (
    .clk(clk), .rst(rst),
    .s0_cs(s0_cs), .s0_addr(s0_addr), .s0_wr_en(s0_wr_en), .s0_rd_en(s0_rd_en),
    .s0_data_wr(s0_data_wr), .s0_data_rd(s0_data_rd), .s0_rdy(s0_rdy),
    .s1_cs(s1_cs), .s1_addr(s1_addr), .s1_wr_en(s1_wr_en), .s1_rd_en(s1_rd_en),
    .s1_data_wr(s1_data_wr), .s1_data_rd(s1_data_rd), .s1_rdy(s1_rdy),
    .m_cs(m_cs), .m_addr(m_addr), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
    .m_data_wr(m_data_wr), .m_data_rd(m_data_rd), .m_rdy(m_rdy),
    .grant(grant), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int n; logic [15:0] addr; logic wr; logic rd; logic [15:0] dat;} bank_t;
  typedef struct {int n; logic [15:0] dat; logic err;} rsp_t;

  bank_t       bank_q[$];
  rsp_t        rsp_q[$];
  logic [15:0] bank_rd_q[$];
  logic [15:0] exp_rd[2];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  int          mrdy_edge = 0;
  int          last_gap = 0;
  int          rdy_cnt[2];
  int          bank_dly = 2;
  bit          bank_en = 1'b1;
  int          wait_cnt = 0;
  logic        m_cs_prev = 1'b0;
  bank_t       cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: raises m_rdy once m_cs has been up for bank_dly cycles.
  always @(posedge clk) begin
    #1;
    m_rdy = 1'b0;
    if (rst || !m_cs) wait_cnt = 0;
    else begin
      wait_cnt++;
      if (bank_en && wait_cnt >= bank_dly) begin
        m_rdy = 1'b1;
        if (m_rd_en) m_data_rd = (bank_rd_q.size() != 0) ? bank_rd_q.pop_front() : 16'hBEEF;
      end
    end
  end

  // Monitor: pops bank and response expectations as the DUT produces them.
  always @(negedge clk) begin
    if (rst) m_cs_prev = 1'b0;
    else begin
      if (m_cs && !m_cs_prev) begin
        last_gap = cyc - mrdy_edge;
        rise_cyc = cyc;
        if (bank_q.size() == 0) check("bank_unexpected", 1, 0);
        else begin
          cur = bank_q.pop_front();
          check("bank_grant", grant, cur.n);
          check("bank_addr", m_addr, cur.addr);
          check("bank_wr", m_wr_en, cur.wr);
          check("bank_rd", m_rd_en, cur.rd);
          check("bank_wdata", m_data_wr, cur.dat);
          check("bank_busy", busy, 1);
        end
      end else if (m_cs && m_cs_prev) begin
        check("bank_hold_addr", m_addr, cur.addr);
      end
      if (m_cs && m_rdy) mrdy_edge = cyc + 1;
      if (s0_rdy || s1_rdy) begin
        check("rdy_onehot", s0_rdy & s1_rdy, 0);
        if (s0_rdy) rdy_cnt[0]++;
        if (s1_rdy) rdy_cnt[1]++;
        if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("rsp_id", s1_rdy ? 1 : 0, r.n);
          check("rsp_data", s1_rdy ? s1_data_rd : s0_data_rd, r.dat);
          check("rsp_err", err, r.err);
          check("rsp_mcs_low", m_cs, 0);
          if (r.err) check("rsp_timeout_latency", cyc - rise_cyc, TO);
          else       check("rsp_latency", cyc, mrdy_edge);
        end
      end
      m_cs_prev = m_cs;
    end
  end

  task automatic drive_req(input int n, input logic cs, input logic [15:0] a,
                           input logic wr, input logic rd, input logic [15:0] d);
    if (n == 0) begin
      s0_cs = cs; s0_addr = a; s0_wr_en = wr; s0_rd_en = rd; s0_data_wr = d;
    end else begin
      s1_cs = cs; s1_addr = a; s1_wr_en = wr; s1_rd_en = rd; s1_data_wr = d;
    end
  endtask

  task automatic wait_rdy(input int n);
    int t = 0;
    logic seen;
    do begin
      @(posedge clk); #1; t++;
      seen = (n == 0) ? s0_rdy : s1_rdy;
    end while (!seen && t < 300);
    check($sformatf("rdy_seen_s%0d", n), seen, 1);
  endtask

  task automatic do_req(input int n, input logic [15:0] a, input logic wr,
                        input logic rd, input logic [15:0] d);
    drive_req(n, 1'b1, a, wr, rd, d);
    wait_rdy(n);
    drive_req(n, 1'b0, a, 1'b0, 1'b0, d);
    @(posedge clk); #1;
  endtask

  task automatic wait_mcs();
    int t = 0;
    do begin @(posedge clk); #1; t++; end while (!m_cs && t < 50);
    check("mcs_seen", m_cs, 1);
  endtask

  task automatic push_bank(input int n, input logic [15:0] a, input logic wr,
                           input logic rd, input logic [15:0] d);
    bank_t b;
    b.n = n; b.addr = a; b.wr = wr; b.rd = rd & ~wr; b.dat = d;
    bank_q.push_back(b);
  endtask

  task automatic push_rsp(input int n, input logic [15:0] d, input logic e);
    rsp_t r;
    r.n = n; r.dat = d; r.err = e;
    rsp_q.push_back(r);
  endtask

  // Full expectation for a transaction that completes normally.
  task automatic expect_txn(input int n, input logic [15:0] a, input logic wr,
                            input logic rd, input logic [15:0] d, input logic [15:0] bank_rdata);
    push_bank(n, a, wr, rd, d);
    if (rd && !wr) begin
      bank_rd_q.push_back(bank_rdata);
      exp_rd[n] = bank_rdata;
    end
    push_rsp(n, exp_rd[n], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    rst = 1'b1;
    drive_req(0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    drive_req(1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    m_rdy = 1'b0; m_data_rd = 16'h0;
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    rdy_cnt[0] = 0; rdy_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_cs", m_cs, 0);
    check("rst_m_wr", m_wr_en, 0);
    check("rst_m_rd", m_rd_en, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_err", err, 0);
    check("rst_rdy", {s0_rdy, s1_rdy}, 0);
    check("rst_data_rd", {s0_data_rd, s1_data_rd}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Contention from reset: s0 wins first, then strict alternation.
    bank_dly = 2;
    for (int i = 0; i < 3; i++) begin
      expect_txn(0, 16'h0100 + 16'(i), 1'b0, 1'b1, 16'h0, 16'(32'h1111 * (2 * i + 1)));
      expect_txn(1, 16'h0200 + 16'(i), 1'b0, 1'b1, 16'h0, 16'(32'h1111 * (2 * i + 2)));
    end
    fork
      begin
        for (int i = 0; i < 3; i++) do_req(0, 16'h0100 + 16'(i), 1'b0, 1'b1, 16'h0);
      end
      begin
        for (int j = 0; j < 3; j++) do_req(1, 16'h0200 + 16'(j), 1'b0, 1'b1, 16'h0);
      end
    join
    check("alt_s0_data", s0_data_rd, 16'h5555);
    check("alt_s1_data", s1_data_rd, 16'h6666);

    // Plain write from s0.
    n_before = rdy_cnt[1];
    expect_txn(0, 16'h0012, 1'b1, 1'b0, 16'hA5A5, 16'h0);
    do_req(0, 16'h0012, 1'b1, 1'b0, 16'hA5A5);
    check("wr_no_s1_rdy", rdy_cnt[1] - n_before, 0);

    // Both strobes set: treated as a write.
    expect_txn(0, 16'h0020, 1'b1, 1'b1, 16'h00FF, 16'h0);
    do_req(0, 16'h0020, 1'b1, 1'b1, 16'h00FF);

    // Abort: s1 drops cs during WAIT; s0 is granted two edges after m_rdy.
    bank_dly = 4;
    n_before = rdy_cnt[1];
    push_bank(1, 16'h0300, 1'b0, 1'b1, 16'h0);
    expect_txn(0, 16'h0301, 1'b1, 1'b0, 16'h5A5A, 16'h0);
    drive_req(1, 1'b1, 16'h0300, 1'b0, 1'b1, 16'h0);
    wait_mcs();
    @(posedge clk); #1;
    drive_req(1, 1'b0, 16'h0300, 1'b0, 1'b0, 16'h0);
    fork
      do_req(0, 16'h0301, 1'b1, 1'b0, 16'h5A5A);
      begin
        @(posedge clk); #1; check("abort_hold_a", m_cs, 1);
        @(posedge clk); #1; check("abort_hold_b", m_cs, 1);
      end
    join
    check("abort_no_s1_rdy", rdy_cnt[1] - n_before, 0);
    check("abort_s1_data", s1_data_rd, exp_rd[1]);
    check("abort_regrant_gap", last_gap, 2);

    // Reset during WAIT drops everything asynchronously.
    bank_dly = 2;
    bank_en = 1'b0;
    push_bank(1, 16'h0400, 1'b0, 1'b1, 16'h0);
    drive_req(1, 1'b1, 16'h0400, 1'b0, 1'b1, 16'h0);
    wait_mcs();
    check("pre_rst_grant", grant, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_m_cs", m_cs, 0);
    check("arst_m_rd", m_rd_en, 0);
    check("arst_busy", busy, 0);
    check("arst_grant", grant, 0);
    check("arst_rdy", {s0_rdy, s1_rdy}, 0);
    drive_req(1, 1'b0, 16'h0400, 1'b0, 1'b0, 16'h0);
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    bank_en = 1'b1;
    @(posedge clk); #1;
    expect_txn(0, 16'h0401, 1'b0, 1'b1, 16'h0, 16'h7777);
    do_req(0, 16'h0401, 1'b0, 1'b1, 16'h0);
    check("post_rst_s1_data", s1_data_rd, 16'h0);

    // Unresponsive bank.
    bank_en = 1'b0;
    push_bank(0, 16'h0500, 1'b0, 1'b1, 16'h0);
`ifdef REG_ARB_TIMEOUT_EN
    push_rsp(0, 16'hDEAD, 1'b1);
    exp_rd[0] = 16'hDEAD;
    do_req(0, 16'h0500, 1'b0, 1'b1, 16'h0);
    check("to_s0_data", s0_data_rd, 16'hDEAD);
    bank_en = 1'b1;
`else
    n_before = rdy_cnt[0];
    drive_req(0, 1'b1, 16'h0500, 1'b0, 1'b1, 16'h0);
    repeat (1000) @(posedge clk);
    #1;
    check("no_rdy_without_timeout", rdy_cnt[0] - n_before, 0);
    check("still_waiting_m_cs", m_cs, 1);
    check("no_err_without_timeout", err, 0);
    push_rsp(0, 16'h9999, 1'b0);
    bank_rd_q.push_back(16'h9999);
    exp_rd[0] = 16'h9999;
    bank_en = 1'b1;
    wait_rdy(0);
    drive_req(0, 1'b0, 16'h0500, 1'b0, 1'b0, 16'h0);
    @(posedge clk); #1;
`endif

    repeat (4) @(posedge clk);
    #1;
    check("end_bank_q_empty", bank_q.size(), 0);
    check("end_rsp_q_empty", rsp_q.size(), 0);
    check("end_idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
